// File: rtl/sr_cmd_gen_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared definitions for the SR command generator:
//   - FSM state encoding
//   - counter widths and counter types
//   - default parameter values
// Optional feature macro used by the design: SR_CMD_GEN_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SET_PULSE = 2'd1,
        ST_CLR_PULSE = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_e;

    localparam int DEB_CNT_W = 8;
    localparam int PH_CNT_W  = 4;

    typedef logic [DEB_CNT_W-1:0] deb_cnt_t;
    typedef logic [PH_CNT_W-1:0]  ph_cnt_t;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int PULSE_LEN_DEF    = 1;
    localparam int HOLDOFF_DEF      = 2;
    localparam int SET_PRIORITY_DEF = 1;

endpackage

// File: rtl/sr_cmd_gen_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
// Conditions one raw request line: 2-flop synchronizer, debouncer, and a
// rising-edge detector on the stable level.
// Macro SR_CMD_GEN_DEBOUNCE_EN: defined -> debouncer present and DEB_CYCLES
// honoured; undefined -> stable level is the synchronizer output directly.
// Ports:
//   clk_i   in  rising-edge clock
//   rst_ni  in  asynchronous active-low reset
//   req_i   in  raw request, asynchronous to clk_i
//   ev_o    out one-cycle event on each 0->1 change of the stable level
// -----------------------------------------------------------------------------
module sr_debounce
    import sr_cmd_pkg::*;
`ifdef SR_CMD_GEN_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic ev_o
);

    logic [1:0] sync_q;
    logic       stable_s;
    logic       prev_q;

    // Two-flop synchronizer for the asynchronous request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], req_i};
        end
    end

`ifdef SR_CMD_GEN_DEBOUNCE_EN
    // Stable level flips on the DEB_CYCLES-th consecutive differing sample
    localparam deb_cnt_t DEB_LAST = deb_cnt_t'(DEB_CYCLES - 1);

    logic     stable_q;
    logic     stable_d;
    deb_cnt_t cnt_q;
    deb_cnt_t cnt_d;

    // Debounce next-state: count samples differing from the stable level
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == DEB_LAST) begin
                stable_d = sync_q[1];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + deb_cnt_t'(1'b1);
            end
        end else begin
            // any sample matching the stable level restarts the count
            cnt_d = '0;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_s = stable_q;
`else
    assign stable_s = sync_q[1];
`endif

    // Previous stable level for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= stable_s;
        end
    end

    assign ev_o = stable_s & ~prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// sr_cmd_gen
// Turns debounced set/clear requests into clean, mutually exclusive,
// fixed-width s/r pulses for a downstream SR flop, with a hold-off window
// after each pulse and suppression of commands that match the flop state.
// Macro SR_CMD_GEN_DEBOUNCE_EN selects the input debouncer (see sr_debounce).
// Ports:
//   clock         in  rising-edge clock
//   reset         in  asynchronous active-low reset
//   set_req       in  raw set request (asynchronous)
//   clr_req       in  raw clear request (asynchronous)
//   y_fb          in  current SR flop output
//   s             out set pulse (registered)
//   r             out reset pulse (registered)
//   busy          out high whenever the FSM is not idle (registered)
//   err_conflict  out one-cycle pulse on coincident set/clear events
// -----------------------------------------------------------------------------
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int PULSE_LEN    = PULSE_LEN_DEF,
    parameter int HOLDOFF      = HOLDOFF_DEF,
    parameter int SET_PRIORITY = SET_PRIORITY_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    input  logic y_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic err_conflict
);

    localparam ph_cnt_t PULSE_LAST = ph_cnt_t'(PULSE_LEN - 1);
    // Only meaningful when HOLDOFF > 0; the state is never entered otherwise
    localparam ph_cnt_t HOLD_LAST  = ph_cnt_t'(HOLDOFF - 1);

    logic    set_ev_s;
    logic    clr_ev_s;
    logic    conflict_s;
    logic    set_want_s;
    logic    clr_want_s;
    state_e  state_q;
    state_e  state_d;
    ph_cnt_t ph_cnt_q;
    ph_cnt_t ph_cnt_d;
    logic    set_pend_q;
    logic    set_pend_d;
    logic    clr_pend_q;
    logic    clr_pend_d;
    logic    s_q;
    logic    r_q;
    logic    busy_q;
    logic    err_q;

`ifdef SR_CMD_GEN_DEBOUNCE_EN
    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
        .clk_i (clock), .rst_ni(reset), .req_i(set_req), .ev_o(set_ev_s)
    );
    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk_i (clock), .rst_ni(reset), .req_i(clr_req), .ev_o(clr_ev_s)
    );
`else
    sr_debounce u_set_deb (
        .clk_i (clock), .rst_ni(reset), .req_i(set_req), .ev_o(set_ev_s)
    );
    sr_debounce u_clr_deb (
        .clk_i (clock), .rst_ni(reset), .req_i(clr_req), .ev_o(clr_ev_s)
    );
`endif

    // Conflict resolution, pending-flag bookkeeping and FSM next-state
    always_comb begin
        conflict_s = set_ev_s & clr_ev_s;
        set_want_s = set_pend_q | set_ev_s;
        clr_want_s = clr_pend_q | clr_ev_s;
        if (conflict_s) begin
            // the losing type is discarded, including any older pending flag
            if (SET_PRIORITY != 0) begin
                clr_want_s = 1'b0;
            end else begin
                set_want_s = 1'b0;
            end
        end else begin
            set_want_s = set_pend_q | set_ev_s;
        end

        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        set_pend_d = set_want_s;
        clr_pend_d = clr_want_s;

        case (state_q)
            ST_IDLE: begin
                ph_cnt_d = '0;
                // y_fb makes at most one request eligible; the other is redundant
                if (!y_fb && set_want_s) begin
                    state_d = ST_SET_PULSE;
                end else if (y_fb && clr_want_s) begin
                    state_d = ST_CLR_PULSE;
                end else begin
                    state_d = ST_IDLE;
                end
                set_pend_d = 1'b0;
                clr_pend_d = 1'b0;
            end
            ST_SET_PULSE, ST_CLR_PULSE: begin
                if (ph_cnt_q == PULSE_LAST) begin
                    ph_cnt_d = '0;
                    if (HOLDOFF != 0) begin
                        state_d = ST_HOLDOFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + ph_cnt_t'(1'b1);
                end
            end
            ST_HOLDOFF: begin
                if (ph_cnt_q == HOLD_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q + ph_cnt_t'(1'b1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ph_cnt_d = '0;
            end
        endcase
    end

    // FSM state, phase counter and pending flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ph_cnt_q   <= '0;
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            set_pend_q <= set_pend_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    // Output registers decoded from next state so they align with the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s_q    <= (state_d == ST_SET_PULSE);
            r_q    <= (state_d == ST_CLR_PULSE);
            busy_q <= (state_d != ST_IDLE);
            err_q  <= conflict_s;
        end
    end

    assign s            = s_q;
    assign r            = r_q;
    assign busy         = busy_q;
    assign err_conflict = err_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_gen
// Self-checking bench for sr_cmd_gen: a table of single-request scenarios,
// hand-written bounce / pending / reset-mid-pulse sequences, and a scoreboard
// of expected pulse and conflict events with their edge numbers.
// -----------------------------------------------------------------------------
module tb_sr_cmd_gen;

    localparam int P_LEN = 1;
    localparam int H_LEN = 2;
`ifdef SR_CMD_GEN_DEBOUNCE_EN
    localparam int LAT           = 7;
    localparam int BOUNCE_PULSES = 1;
`else
    localparam int LAT           = 3;
    localparam int BOUNCE_PULSES = 6;
`endif

    typedef struct {
        int kind;      // 0 = s, 1 = r, 2 = err_conflict
        int at_edge;
    } exp_t;

    typedef struct {
        string name;
        logic  y;
        logic  set;
        logic  clr;
        int    ns;
        int    nr;
        int    nerr;
        int    nbusy;
    } vec_t;

    logic clock = 1'b0;
    logic reset, set_req, clr_req, y_fb;
    logic s, r, busy, err_conflict;
    logic reset8, set_req8, clr_req8, y_fb8;
    logic s8, r8, busy8, err8;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   n_s, n_r, n_err, n_busy, n_s8, n_busy8;
    exp_t sbq[$];
    vec_t vecs[7];

    sr_cmd_gen dut (
        .clock(clock), .reset(reset), .set_req(set_req), .clr_req(clr_req),
        .y_fb(y_fb), .s(s), .r(r), .busy(busy), .err_conflict(err_conflict)
    );

    sr_cmd_gen #(.PULSE_LEN(8)) dut8 (
        .clock(clock), .reset(reset8), .set_req(set_req8), .clr_req(clr_req8),
        .y_fb(y_fb8), .s(s8), .r(r8), .busy(busy8), .err_conflict(err8)
    );

    always #5 clock = ~clock;

    // Count rising edges so expectations can name the edge an event lands on
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_exp(input int kind, input int at_edge);
        exp_t e;
        e.kind    = kind;
        e.at_edge = at_edge;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_unexpected_event", kind, -1);
        end else begin
            e = sbq.pop_front();
            check("sb_kind", kind, e.kind);
            check("sb_edge", edge_cnt, e.at_edge);
        end
    endtask

    // Monitor on the falling edge: scoreboard, exclusivity, pulse widths
    initial begin
        logic s_prev, r_prev, e_prev, s8_prev;
        int   s_w, r_w;
        s_prev = 1'b0; r_prev = 1'b0; e_prev = 1'b0; s8_prev = 1'b0;
        s_w = 0; r_w = 0;
        forever begin
            @(negedge clock);
            check("s_r_exclusive", int'(s & r), 0);
            if (s && !s_prev) begin n_s++; sb_pop(0); end
            if (r && !r_prev) begin n_r++; sb_pop(1); end
            if (err_conflict && !e_prev) begin n_err++; sb_pop(2); end
            if (busy) n_busy++;
            if (s) s_w++;
            else begin
                if (s_prev) check("s_width", s_w, P_LEN);
                s_w = 0;
            end
            if (r) r_w++;
            else begin
                if (r_prev) check("r_width", r_w, P_LEN);
                r_w = 0;
            end
            if (s8 && !s8_prev) n_s8++;
            if (busy8) n_busy8++;
            s_prev = s; r_prev = r; e_prev = err_conflict; s8_prev = s8;
        end
    end

    task automatic clear_counts();
        n_s = 0; n_r = 0; n_err = 0; n_busy = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        clear_counts();
        @(negedge clock);
        y_fb = v.y; set_req = v.set; clr_req = v.clr;
        base = edge_cnt;
        if (v.ns > 0)   push_exp(0, base + LAT);
        if (v.nr > 0)   push_exp(1, base + LAT);
        if (v.nerr > 0) push_exp(2, base + LAT);
        repeat (14) @(negedge clock);
        set_req = 1'b0; clr_req = 1'b0;
        repeat (14) @(negedge clock);
        check({v.name, "_s_count"},    n_s,    v.ns);
        check({v.name, "_r_count"},    n_r,    v.nr);
        check({v.name, "_err_count"},  n_err,  v.nerr);
        check({v.name, "_busy_cycles"}, n_busy, v.nbusy);
    endtask

    initial begin
        int base;
        vecs[0] = '{"set_clean",   1'b0, 1'b1, 1'b0, 1, 0, 0, 3};
        vecs[1] = '{"clr_redund",  1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
        vecs[2] = '{"set_redund",  1'b1, 1'b1, 1'b0, 0, 0, 0, 0};
        vecs[3] = '{"clr_clean",   1'b1, 1'b0, 1'b1, 0, 1, 0, 3};
        vecs[4] = '{"both_y0",     1'b0, 1'b1, 1'b1, 1, 0, 1, 3};
        vecs[5] = '{"both_y1",     1'b1, 1'b1, 1'b1, 0, 0, 1, 0};
        vecs[6] = '{"quiet",       1'b1, 1'b0, 1'b0, 0, 0, 0, 0};

        reset = 1'b0; set_req = 1'b0; clr_req = 1'b0; y_fb = 1'b0;
        reset8 = 1'b0; set_req8 = 1'b0; clr_req8 = 1'b0; y_fb8 = 1'b0;
        clear_counts();
        n_s8 = 0; n_busy8 = 0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_s", int'(s), 0);
        check("rst_r", int'(r), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_conflict), 0);
        check("rst8_s", int'(s8), 0);
        reset = 1'b1; reset8 = 1'b1;
        repeat (3) @(negedge clock);

        // Table of single-request scenarios
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high
        clear_counts();
        y_fb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            set_req = ((i % 4) < 2);
`ifndef SR_CMD_GEN_DEBOUNCE_EN
            if ((i % 4) == 0) push_exp(0, edge_cnt + LAT);
`endif
        end
        @(negedge clock);
        set_req = 1'b1;
        push_exp(0, edge_cnt + LAT);
        repeat (14) @(negedge clock);
        set_req = 1'b0;
        repeat (14) @(negedge clock);
        check("bounce_s_count", n_s, BOUNCE_PULSES);
        check("bounce_r_count", n_r, 0);

        // Pending: clear arrives during SET_PULSE, flop follows the set
        clear_counts();
        y_fb = 1'b0;
        @(negedge clock);
        set_req = 1'b1;
        base = edge_cnt;
        push_exp(0, base + LAT);
        @(negedge clock);
        clr_req = 1'b1;
        push_exp(1, base + LAT + P_LEN + H_LEN + 1);
        repeat (LAT - 1) @(negedge clock);
        y_fb = 1'b1;
        repeat (P_LEN + H_LEN + 1) @(negedge clock);
        y_fb = 1'b0;
        repeat (6) @(negedge clock);
        set_req = 1'b0; clr_req = 1'b0;
        repeat (14) @(negedge clock);
        check("pend_s_count", n_s, 1);
        check("pend_r_count", n_r, 1);
        check("pend_busy_cycles", n_busy, 2 * (P_LEN + H_LEN));

        // Reset asserted on cycle 3 of an 8-cycle pulse
        @(negedge clock);
        set_req8 = 1'b1;
        repeat (LAT - 1) @(negedge clock);
        check("rst8_s_before", int'(s8), 0);
        repeat (3) @(negedge clock);
        check("rst8_s_cycle3", int'(s8), 1);
        check("rst8_busy_cycle3", int'(busy8), 1);
        reset8 = 1'b0; set_req8 = 1'b0;
        #1;
        check("rst8_s_async", int'(s8), 0);
        check("rst8_busy_async", int'(busy8), 0);
        check("rst8_r_async", int'(r8), 0);
        repeat (3) @(negedge clock);
        reset8 = 1'b1;
        n_s8 = 0; n_busy8 = 0;
        repeat (30) @(negedge clock);
        check("rst8_no_pulse_after", n_s8, 0);
        check("rst8_no_busy_after", n_busy8, 0);

        check("sb_missing_events", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
